// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store controller.
//   - mem_op size encodings and the unsigned-load bit index
//   - controller FSM state type
//   - pmem_read / pmem_write: the physical-memory access routines. They are plain SV functions
//     over a small byte array and keep the same argument shape as the C model (64-bit address,
//     64-bit data, 8-bit byte mask), so both supported data widths can call them.
//     pmem_peek reads the array without counting as an access.
package lsu_mem_ctrl_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam logic [1:0] MEM_D = 2'b11;
  localparam int unsigned MEM_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} lsu_state_e;

  localparam int unsigned PmemBytes = 4096;

  // Only the low 12 address bits select a byte, so the model wraps every 4 KiB.
  logic [7:0]  pmem_mem [PmemBytes] = '{default: 8'h00};
  int unsigned pmem_rd_cnt = 0;
  int unsigned pmem_wr_cnt = 0;
  logic [63:0] pmem_last_waddr = '0;
  logic [63:0] pmem_last_wdata = '0;
  logic [7:0]  pmem_last_wmask = '0;

  function automatic logic [63:0] pmem_peek(input logic [63:0] addr);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      d[8*i +: 8] = pmem_mem[12'(addr + 64'(i))];
    end
    return d;
  endfunction

  function automatic logic [63:0] pmem_read(input logic [63:0] addr);
    pmem_rd_cnt = pmem_rd_cnt + 1;
    return pmem_peek(addr);
  endfunction

  function automatic void pmem_write(input logic [63:0] addr, input logic [63:0] data,
                                     input logic [7:0] mask);
    pmem_wr_cnt     = pmem_wr_cnt + 1;
    pmem_last_waddr = addr;
    pmem_last_wdata = data;
    pmem_last_wmask = mask;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) pmem_mem[12'(addr + 64'(i))] = data[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane alignment for one memory access.
//   op_i        : [1:0] size, [2] unsigned load
//   offset_i    : byte lane offset within the data word
//   wdata_i     : right-aligned store data
//   rdata_raw_i : full word returned by memory
//   wmask_o     : byte mask shifted to the lane
//   wdata_o     : store data shifted to the lane
//   rdata_o     : load data shifted down and sign/zero-extended
//   illegal_o   : misaligned access or size not supported by this data width
module lsu_align
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned NumBytes  = DATA_WIDTH / 8,
  localparam int unsigned OffW      = $clog2(NumBytes)
) (
  input  logic [2:0]            op_i,
  input  logic [OffW-1:0]       offset_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_raw_i,
  output logic [NumBytes-1:0]   wmask_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  illegal_o
);

  logic [OffW+2:0]       shamt;
  logic [NumBytes-1:0]   base_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep;
  logic                  msb;

  assign shamt   = {offset_i, 3'b000};
  assign wdata_o = wdata_i << shamt;
  assign wmask_o = base_mask << offset_i;
  assign shifted = rdata_raw_i >> shamt;
  // Bits outside 'keep' are filled with the sign bit unless the load is unsigned.
  assign rdata_o = (shifted & keep) |
                   ({DATA_WIDTH{msb & ~op_i[MEM_UNSIGNED_BIT]}} & ~keep);

  always_comb begin
    base_mask = '1;
    keep      = '1;
    msb       = shifted[DATA_WIDTH-1];
    illegal_o = 1'b0;
    unique case (op_i[1:0])
      MEM_B: begin
        base_mask = NumBytes'(8'h01);
        keep      = DATA_WIDTH'(64'hFF);
        msb       = shifted[7];
      end
      MEM_H: begin
        base_mask = NumBytes'(8'h03);
        keep      = DATA_WIDTH'(64'hFFFF);
        msb       = shifted[15];
        illegal_o = offset_i[0];
      end
      MEM_W: begin
        base_mask = NumBytes'(8'h0F);
        keep      = DATA_WIDTH'(64'hFFFF_FFFF);
        msb       = shifted[31];
        illegal_o = |offset_i[1:0];
      end
      MEM_D: begin
        illegal_o = (DATA_WIDTH == 32) || (|offset_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Sequential load/store controller between execute and the physical-memory model.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_valid_i/ready_o   : request handshake; req_wen_i, req_addr_i, req_wdata_i, req_op_i
//   resp_valid_o/ready_i  : response handshake; resp_rdata_o (extended load data), resp_err_o
// One word-aligned memory access per legal request, issued on the edge that leaves StWait.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wen_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [2:0]            req_op_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned CntW     = $clog2(LATENCY + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  lsu_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] raw_q;
  logic [2:0]            op_q;
  logic                  err_q;

  logic                  accept;
  logic                  access;
  logic [2:0]            al_op;
  logic [OffW-1:0]       al_off;
  logic [NumBytes-1:0]   al_wmask;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_rdata;
  logic                  al_illegal;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign accept    = (state_q == StIdle) && req_valid_i;
  assign access    = (state_q == StWait) && (cnt_q == '0) && !err_q;
  assign word_addr = {addr_q[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};

  // In idle the aligner checks the incoming request; afterwards it works on the captured one.
  assign al_op  = (state_q == StIdle) ? req_op_i : op_q;
  assign al_off = (state_q == StIdle) ? req_addr_i[OffW-1:0] : addr_q[OffW-1:0];

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .op_i        (al_op),
    .offset_i    (al_off),
    .wdata_i     (wdata_q),
    .rdata_raw_i (raw_q),
    .wmask_o     (al_wmask),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata),
    .illegal_o   (al_illegal)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          // Illegal requests spend one cycle in StWait (no access) so the error response
          // appears one edge after acceptance.
          state_d = StWait;
          cnt_d   = al_illegal ? '0 : CntInit;
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == StIdle) && !rst_i;
    resp_valid_o = (state_q == StResp);
    resp_err_o   = (state_q == StResp) && err_q;
    resp_rdata_o = ((state_q == StResp) && !wen_q && !err_q) ? al_rdata : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      raw_q   <= '0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        op_q    <= req_op_i;
        err_q   <= al_illegal;
      end
      if (access) begin
        if (wen_q) pmem_write(64'(word_addr), 64'(al_wdata), 8'(al_wmask));
        else       raw_q <= DATA_WIDTH'(pmem_read(64'(word_addr)));
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: one 32-bit instance (LATENCY=3) and one 64-bit
// instance (LATENCY=2) sharing request inputs, each with its own req_valid.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  localparam int unsigned Lat32 = 3;
  localparam int unsigned Lat64 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid32 = 1'b0, valid64 = 1'b0;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  req_op = '0;
  logic        resp_ready = 1'b1;

  logic        ready32, rv32, err32;
  logic [31:0] rdata32;
  logic        ready64, rv64, err64;
  logic [63:0] rdata64;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(Lat32)) dut32 (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (valid32),
    .req_ready_o  (ready32),
    .req_wen_i    (req_wen),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata[31:0]),
    .req_op_i     (req_op),
    .resp_valid_o (rv32),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (rdata32),
    .resp_err_o   (err32)
  );

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .LATENCY(Lat64)) dut64 (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (valid64),
    .req_ready_o  (ready64),
    .req_wen_i    (req_wen),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_op_i     (req_op),
    .resp_valid_o (rv64),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (rdata64),
    .resp_err_o   (err64)
  );

  typedef struct {
    string       nm;
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [2:0]  op;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wdata;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic wen, input logic [31:0] addr,
                              input logic [63:0] wdata, input logic [2:0] op,
                              input logic [63:0] exp_rdata, input logic exp_err,
                              input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
    vec_t v;
    v.nm = nm; v.wen = wen; v.addr = addr; v.wdata = wdata; v.op = op;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_mask = exp_mask;
    v.exp_wdata = exp_wdata;
    return v;
  endfunction

  function automatic logic o_ready(input bit w64);
    return w64 ? ready64 : ready32;
  endfunction
  function automatic logic o_rv(input bit w64);
    return w64 ? rv64 : rv32;
  endfunction
  function automatic logic o_err(input bit w64);
    return w64 ? err64 : err32;
  endfunction
  function automatic logic [63:0] o_rdata(input bit w64);
    return w64 ? rdata64 : {32'h0, rdata32};
  endfunction

  task automatic run_txn(input bit w64, input vec_t v);
    int unsigned rd0, wr0;
    int          cyc;
    int          lat;
    logic [31:0] wa;
    lat = v.exp_err ? 1 : int'(w64 ? Lat64 : Lat32);
    wa  = w64 ? (v.addr & 32'hFFFF_FFF8) : (v.addr & 32'hFFFF_FFFC);
    @(negedge clk);
    req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata; req_op = v.op;
    resp_ready = 1'b1;
    chk({v.nm, " req_ready idle"}, 64'(o_ready(w64)), 64'd1);
    rd0 = pmem_rd_cnt;
    wr0 = pmem_wr_cnt;
    if (w64) valid64 = 1'b1; else valid32 = 1'b1;
    @(posedge clk); #1;
    valid32 = 1'b0; valid64 = 1'b0;
    cyc = 0;
    while (!o_rv(w64) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({v.nm, " latency"}, 64'(cyc), 64'(lat));
    chk({v.nm, " rdata"}, o_rdata(w64), v.exp_rdata);
    chk({v.nm, " err"}, 64'(o_err(w64)), 64'(v.exp_err));
    chk({v.nm, " req_ready busy"}, 64'(o_ready(w64)), 64'd0);
    chk({v.nm, " reads"}, 64'(pmem_rd_cnt - rd0), (!v.wen && !v.exp_err) ? 64'd1 : 64'd0);
    chk({v.nm, " writes"}, 64'(pmem_wr_cnt - wr0), (v.wen && !v.exp_err) ? 64'd1 : 64'd0);
    if (v.wen && !v.exp_err) begin
      chk({v.nm, " wmask"}, 64'(pmem_last_wmask), 64'(v.exp_mask));
      chk({v.nm, " wdata"}, pmem_last_wdata, v.exp_wdata);
      chk({v.nm, " waddr"}, pmem_last_waddr, 64'(wa));
    end
    @(posedge clk); #1;
    chk({v.nm, " resp done"}, 64'(o_rv(w64)), 64'd0);
    chk({v.nm, " ready again"}, 64'(o_ready(w64)), 64'd1);
  endtask

  vec_t v32[14];
  vec_t v64[8];

  initial begin
    int unsigned rd0, wr0;
    int          cyc;

    v32[0]  = mk("sw",         1, 32'h8000_0000, 64'hDEAD_BEEF, 3'b010, 0, 0, 8'h0F, 64'hDEAD_BEEF);
    v32[1]  = mk("lw",         0, 32'h8000_0000, 0, 3'b010, 64'hDEAD_BEEF, 0, 0, 0);
    v32[2]  = mk("sb",         1, 32'h8000_0001, 64'hAB, 3'b000, 0, 0, 8'h02, 64'h0000_AB00);
    v32[3]  = mk("lb",         0, 32'h8000_0001, 0, 3'b000, 64'hFFFF_FFAB, 0, 0, 0);
    v32[4]  = mk("lbu",        0, 32'h8000_0001, 0, 3'b100, 64'h0000_00AB, 0, 0, 0);
    v32[5]  = mk("lh",         0, 32'h8000_0002, 0, 3'b001, 64'hFFFF_DEAD, 0, 0, 0);
    v32[6]  = mk("lhu",        0, 32'h8000_0002, 0, 3'b101, 64'h0000_DEAD, 0, 0, 0);
    v32[7]  = mk("lh mis",     0, 32'h8000_0003, 0, 3'b001, 0, 1, 0, 0);
    v32[8]  = mk("ld rsv",     0, 32'h8000_0000, 0, 3'b011, 0, 1, 0, 0);
    v32[9]  = mk("sw mis",     1, 32'h8000_0002, 64'h5555_5555, 3'b010, 0, 1, 0, 0);
    v32[10] = mk("sb op2",     1, 32'h8000_0003, 64'h12, 3'b100, 0, 0, 8'h08, 64'h1200_0000);
    v32[11] = mk("lwu",        0, 32'h8000_0000, 0, 3'b110, 64'h12AD_ABEF, 0, 0, 0);
    v32[12] = mk("sh",         1, 32'h8000_0002, 64'h1234_5678, 3'b001, 0, 0, 8'h0C,
                 64'h5678_0000);
    v32[13] = mk("lh pos",     0, 32'h8000_0002, 0, 3'b001, 64'h0000_5678, 0, 0, 0);

    v64[0] = mk("sd64",  1, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 3'b011, 0, 0, 8'hFF,
                64'h0123_4567_89AB_CDEF);
    v64[1] = mk("ld64",  0, 32'h8000_0008, 0, 3'b011, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
    v64[2] = mk("lw64 hi", 0, 32'h8000_000C, 0, 3'b010, 64'h0000_0000_0123_4567, 0, 0, 0);
    v64[3] = mk("lw64 lo", 0, 32'h8000_0008, 0, 3'b010, 64'hFFFF_FFFF_89AB_CDEF, 0, 0, 0);
    v64[4] = mk("lbu64", 0, 32'h8000_000F, 0, 3'b100, 64'h01, 0, 0, 0);
    v64[5] = mk("ld64 mis", 0, 32'h8000_000C, 0, 3'b011, 0, 1, 0, 0);
    v64[6] = mk("sh64",  1, 32'h8000_000E, 64'hBEEF, 3'b001, 0, 0, 8'hC0,
                64'hBEEF_0000_0000_0000);
    v64[7] = mk("lh64",  0, 32'h8000_000E, 0, 3'b001, 64'hFFFF_FFFF_FFFF_BEEF, 0, 0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready32", 64'(ready32), 64'd0);
    chk("rst rv32", 64'(rv32), 64'd0);
    chk("rst rdata32", 64'(rdata32), 64'd0);
    chk("rst err32", 64'(err32), 64'd0);
    chk("rst ready64", 64'(ready64), 64'd0);
    chk("rst rv64", 64'(rv64), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst ready32", 64'(ready32), 64'd1);
    chk("post-rst ready64", 64'(ready64), 64'd1);

    for (int i = 0; i < 14; i++) run_txn(1'b0, v32[i]);

    // Back-pressure: response held 5 cycles while a competing request is offered
    @(negedge clk);
    req_wen = 1'b0; req_addr = 32'h8000_0000; req_op = 3'b010; resp_ready = 1'b0;
    rd0 = pmem_rd_cnt; wr0 = pmem_wr_cnt;
    valid32 = 1'b1;
    @(posedge clk); #1;
    valid32 = 1'b0;
    cyc = 0;
    while (!rv32 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp latency", 64'(cyc), 64'(Lat32));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_wen = 1'b1; req_wdata = 64'hFFFF_FFFF; req_op = 3'b010; valid32 = 1'b1;
      #1;
      chk("bp valid", 64'(rv32), 64'd1);
      chk("bp rdata", 64'(rdata32), 64'h5678_ABEF);
      chk("bp ready", 64'(ready32), 64'd0);
    end
    @(negedge clk);
    valid32 = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp done", 64'(rv32), 64'd0);
    chk("bp idle", 64'(ready32), 64'd1);
    chk("bp reads", 64'(pmem_rd_cnt - rd0), 64'd1);
    chk("bp writes", 64'(pmem_wr_cnt - wr0), 64'd0);
    chk("bp mem", pmem_peek(64'h8000_0000) & 64'hFFFF_FFFF, 64'h5678_ABEF);

    // Reset while a store waits for memory
    @(negedge clk);
    req_wen = 1'b1; req_addr = 32'h8000_0004; req_wdata = 64'h1111_1111; req_op = 3'b010;
    wr0 = pmem_wr_cnt;
    valid32 = 1'b1;
    @(posedge clk); #1;
    valid32 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-rst ready", 64'(ready32), 64'd0);
    chk("mid-rst valid", 64'(rv32), 64'd0);
    chk("mid-rst err", 64'(err32), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid-rst release", 64'(ready32), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("mid-rst no write", 64'(pmem_wr_cnt - wr0), 64'd0);
    chk("mid-rst mem", pmem_peek(64'h8000_0004) & 64'hFFFF_FFFF, 64'd0);
    run_txn(1'b0, mk("lw after rst", 0, 32'h8000_0004, 0, 3'b010, 64'd0, 0, 0, 0));

    for (int i = 0; i < 8; i++) run_txn(1'b1, v64[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
